// File: rtl/fifo_level.sv
// Synchronous FIFO with binary pointers, occupancy level, almost-full/almost-empty flags and flush.
// Define FIFO_LEVEL_ERRFLAG_EN to build the sticky overflow/underflow flags (ovf/udf).
module fifo_level #(
  parameter int CUT_READY         = 0,
  parameter int ZEROOUT_WHENEMPTY = 0,
  parameter int DP                = 16,
  parameter int DW                = 16,
  parameter int LW                = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          w_req,
  output logic          unfull,
  input  logic [DW-1:0] data_i,
  input  logic          r_req,
  output logic          unempty,
  output logic [DW-1:0] data_o,
  output logic [LW-1:0] level,
  input  logic [LW-1:0] af_thr,
  input  logic [LW-1:0] ae_thr,
  output logic          almost_full,
  output logic          almost_empty,
  input  logic          err_clr,
  output logic          ovf,
  output logic          udf
);

  localparam int            PW       = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DP);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] level_nxt;
  logic          wen;
  logic          ren;

  // Pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign ren    = r_req & unempty;
  assign unfull = (level != LVL_FULL) | ((CUT_READY == 0) & ren);
  assign wen    = w_req & unfull;

  assign almost_full  = (level >= af_thr);
  assign almost_empty = (level <= ae_thr);

  assign data_o = ((ZEROOUT_WHENEMPTY != 0) && !unempty) ? '0 : mem[rptr];

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (wen & ~ren)
      level_nxt = level + 1'b1;
    else if (ren & ~wen)
      level_nxt = level - 1'b1;
  end

  // unempty is registered from the next level so the read-valid output comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      unempty <= 1'b0;
    end else begin
      level   <= level_nxt;
      unempty <= (level_nxt != '0);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wen) wptr <= ptr_inc(wptr);
        if (ren) rptr <= ptr_inc(rptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wen & ~flush)
      mem[wptr] <= data_i;
  end

`ifdef FIFO_LEVEL_ERRFLAG_EN
  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (w_req & ~unfull)
        ovf <= 1'b1;
      else if (err_clr)
        ovf <= 1'b0;
      if (r_req & ~unempty)
        udf <= 1'b1;
      else if (err_clr)
        udf <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level: a CUT_READY=0 instance and a CUT_READY=1/ZEROOUT=1 instance share stimulus.
module tb_fifo_level;
  localparam int DP = 4;
  localparam int DW = 8;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, w_req, r_req, err_clr;
  logic [DW-1:0] data_i;
  logic [LW-1:0] af_thr, ae_thr;

  logic          unfull0, unempty0, af0, ae0, ovf0, udf0;
  logic [DW-1:0] dout0;
  logic [LW-1:0] lvl0;
  logic          unfull1, unempty1, af1, ae1, ovf1, udf1;
  logic [DW-1:0] dout1;
  logic [LW-1:0] lvl1;

  fifo_level #(.CUT_READY(0), .ZEROOUT_WHENEMPTY(0), .DP(DP), .DW(DW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_req(w_req), .unfull(unfull0),
    .data_i(data_i), .r_req(r_req), .unempty(unempty0), .data_o(dout0), .level(lvl0),
    .af_thr(af_thr), .ae_thr(ae_thr), .almost_full(af0), .almost_empty(ae0),
    .err_clr(err_clr), .ovf(ovf0), .udf(udf0)
  );

  fifo_level #(.CUT_READY(1), .ZEROOUT_WHENEMPTY(1), .DP(DP), .DW(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_req(w_req), .unfull(unfull1),
    .data_i(data_i), .r_req(r_req), .unempty(unempty1), .data_o(dout1), .level(lvl1),
    .af_thr(af_thr), .ae_thr(ae_thr), .almost_full(af1), .almost_empty(ae1),
    .err_clr(err_clr), .ovf(ovf1), .udf(udf1)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_ovf0, m_udf0, m_ovf1, m_udf1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_side(input string tag, input logic uf, input logic ue, input logic af,
                            input logic ae, input logic ov, input logic ud, input logic [LW-1:0] lv,
                            input logic [DW-1:0] dout, input int n, input logic [DW-1:0] head,
                            input logic exp_uf, input logic zo, input logic eo, input logic eu);
    check({tag, " level"}, lv, n);
    check({tag, " unempty"}, ue, n != 0);
    check({tag, " unfull"}, uf, exp_uf);
    check({tag, " almost_full"}, af, n >= int'(af_thr));
    check({tag, " almost_empty"}, ae, n <= int'(ae_thr));
    check({tag, " ovf"}, ov, eo);
    check({tag, " udf"}, ud, eu);
    if (n != 0)
      check({tag, " data_o"}, dout, head);
    else if (zo)
      check({tag, " data_o zero"}, dout, '0);
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic fl,
                      input logic ec, input string tag);
    logic          uf0, uf1, wen0, wen1, ren0, ren1;
    logic [DW-1:0] h0, h1;
    int            n0, n1;
    @(negedge clk);
    w_req = w; data_i = d; r_req = r; flush = fl; err_clr = ec;
    #1;
    n0 = q0.size();
    n1 = q1.size();
    h0 = '0;
    h1 = '0;
    if (n0 != 0) h0 = q0[0];
    if (n1 != 0) h1 = q1[0];
    uf0 = (n0 != DP) || (r && n0 != 0);
    uf1 = (n1 != DP);
    check_side({tag, "/c0"}, unfull0, unempty0, af0, ae0, ovf0, udf0, lvl0, dout0,
               n0, h0, uf0, 1'b0, m_ovf0, m_udf0);
    check_side({tag, "/c1"}, unfull1, unempty1, af1, ae1, ovf1, udf1, lvl1, dout1,
               n1, h1, uf1, 1'b1, m_ovf1, m_udf1);
    ren0 = r && n0 != 0;
    ren1 = r && n1 != 0;
    wen0 = w && uf0;
    wen1 = w && uf1;
    @(posedge clk);
`ifdef FIFO_LEVEL_ERRFLAG_EN
    m_ovf0 = (w && !uf0) ? 1'b1 : (ec ? 1'b0 : m_ovf0);
    m_ovf1 = (w && !uf1) ? 1'b1 : (ec ? 1'b0 : m_ovf1);
    m_udf0 = (r && n0 == 0) ? 1'b1 : (ec ? 1'b0 : m_udf0);
    m_udf1 = (r && n1 == 0) ? 1'b1 : (ec ? 1'b0 : m_udf1);
`endif
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ren0) void'(q0.pop_front());
      if (wen0) q0.push_back(d);
      if (ren1) void'(q1.pop_front());
      if (wen1) q1.push_back(d);
    end
  endtask

  // Reset is asserted between clock edges, so the checks see its asynchronous effect.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; w_req = 1'b0; r_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
    check_side({tag, "/c0"}, unfull0, unempty0, af0, ae0, ovf0, udf0, lvl0, dout0,
               0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_side({tag, "/c1"}, unfull1, unempty1, af1, ae1, ovf1, udf1, lvl1, dout1,
               0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; w_req = 1'b0; r_req = 1'b0; err_clr = 1'b0;
    data_i = '0; af_thr = 3'd3; ae_thr = 3'd1;
    m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
    do_reset("reset");

    af_thr = 3'd0;
    #1;
    check("af_thr0/c0", af0, 1'b1);
    check("af_thr0/c1", af1, 1'b1);
    af_thr = 3'd3;

    step(1, 8'h11, 0, 0, 0, "fill");
    step(1, 8'h22, 0, 0, 0, "fill");
    step(1, 8'h33, 0, 0, 0, "fill");
    step(1, 8'h44, 0, 0, 0, "fill");
    step(0, 8'h00, 0, 0, 0, "full");
    step(1, 8'h55, 1, 0, 0, "full_rw");
    step(1, 8'h55, 0, 0, 0, "retry");
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, "drain");
    step(0, 8'h00, 1, 0, 1, "udf_clr");
    step(0, 8'h00, 0, 0, 0, "empty");

    for (int i = 0; i < 6; i++) step(1, 8'($urandom), i > 0, 0, 0, "wrap");
    step(0, 8'h00, 1, 0, 0, "wrap_last");

    for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0, 0, 0, "fill2");
    step(1, 8'hEE, 0, 0, 0, "ovf");
    step(0, 8'h00, 1, 0, 0, "to3");
    step(1, 8'h77, 0, 1, 0, "flush");
    step(0, 8'h00, 0, 0, 0, "post_flush");
    step(0, 8'h00, 1, 0, 0, "flush_empty_rd");

    step(1, 8'h99, 1, 0, 0, "empty_rw");
    step(0, 8'h00, 0, 0, 0, "after_rw");
    step(0, 8'h00, 1, 0, 0, "rd99");

    step(1, 8'h12, 0, 0, 0, "pre_rst");
    step(1, 8'h34, 0, 0, 0, "pre_rst");
    do_reset("async_reset");
    step(0, 8'h00, 0, 0, 0, "post_rst");

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < ((i < 100) ? 70 : 30), 8'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) == 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO for the 1553B/APB datapath, the successor to the one-hot simple FIFO. It uses binary read/write pointers, so any depth is practical, and exposes an occupancy level. It adds programmable almost-full and almost-empty flags, a synchronous flush and optional sticky overflow/underflow flags. It sits between the APB register file and the 1553B encoder/decoder to buffer message words, and its flags are readable as status.

## Interface
- `CUT_READY`, default 0: when 0, `unfull` also asserts when full while a read is accepted in the same cycle; when 1, `unfull` depends only on the level.
- `ZEROOUT_WHENEMPTY`, default 0: when 1, `data_o` is forced to 0 while `unempty`=0.
- `DP`, default 16: depth in entries. Legal range is DP ≥ 2; any value, not only powers of two.
- `DW`, default 16: data width in bits.
- `LW`, default `$clog2(DP+1)`: level width. Derived; do not override.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of the FIFO contents.
- `w_req`  in  1  write request.
- `unfull`  out  1  write ready.
- `data_i`  in  DW  write data.
- `r_req`  in  1  read request.
- `unempty`  out  1  read valid.
- `data_o`  out  DW  head-of-FIFO data (first-word fall-through).
- `level`  out  LW  current number of stored entries, 0..DP.
- `af_thr`  in  LW  almost-full threshold.
- `ae_thr`  in  LW  almost-empty threshold.
- `almost_full`  out  1  `level >= af_thr`.
- `almost_empty`  out  1  `level <= ae_thr`.
- `err_clr`  in  1  clears the sticky error flags.
- `ovf`  out  1  sticky overflow flag.
- `udf`  out  1  sticky underflow flag.

## Operation
- Handshakes: `wen = w_req & unfull`; `ren = r_req & unempty`.
- Write pointer: `wptr`, binary, 0..DP-1. It advances on `wen` and wraps from DP-1 to 0.
- Read pointer: `rptr`, binary, 0..DP-1. It advances on `ren` and wraps from DP-1 to 0.
- Level register:
  - +1 on `wen & ~ren`.
  - −1 on `ren & ~wen`.
  - Unchanged on both or neither.
- `unempty = (level != 0)`, driven from a registered compare (flop-clean).
- `unfull = (level != DP)`, OR'd with `ren` when `CUT_READY`=0.
- Storage registers are not reset. `data_o` is `mem[rptr]`, combinational.
- There is no write-to-read bypass. When empty, a simultaneous write and read accepts only the write.
- `flush` has priority over `wen` and `ren` in the same cycle. It sets pointers and level to 0. Data presented on `data_i` that cycle is dropped.
- `almost_full` and `almost_empty` are combinational compares of the registered `level` against the live thresholds. A threshold change takes effect in the same cycle.

## Timing
- Reset values:
  - `level`=0, `unempty`=0, `unfull`=1.
  - `ovf`=0, `udf`=0.
  - `almost_empty`=1.
  - `almost_full`=1 only if `af_thr`=0.
  - `data_o`=0 when `ZEROOUT_WHENEMPTY`=1, otherwise undefined.
- Write latency: data written at edge N appears on `data_o` with `unempty`=1 after edge N.
- Read: `ren` at edge N exposes the next entry after edge N.
- Full with `CUT_READY`=0: a simultaneous read and write are both accepted and `level` stays at DP.
- Full with `CUT_READY`=1: the write is refused. The read completes, and a retried write is accepted on the following cycle.
- Wrap: both pointers wrap DP-1 → 0 with no bubble.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The contents are lost.
- Flush asserted mid-operation: `unempty`=0 and `level`=0 after the flush edge.

## Configuration
- Macro: `FIFO_LEVEL_ERRFLAG_EN`.
- Defined:
  - `ovf` sets on `w_req & ~unfull`.
  - `udf` sets on `r_req & ~unempty`.
  - Both clear on `err_clr`. A set in the same cycle as `err_clr` wins.
  - `flush` does not clear the flags.
- Undefined: `ovf` and `udf` are tied to 0, `err_clr` is ignored, and no error-flag registers are built.

## Test plan
All scenarios use DP=4, DW=8, `af_thr`=3, `ae_thr`=1.
- Reset, then write 0x11, 0x22, 0x33, 0x44 → `level` steps 1,2,3,4. `almost_full` asserts at `level`=3. `unfull`=0 at 4. `almost_empty` deasserts at `level`=2.
- Full, `CUT_READY`=0, simultaneous write 0x55 and read → reads 0x11, `level` stays 4. Then drain → 0x22, 0x33, 0x44, 0x55, with `unempty`=0 after the last read.
- Six write/read pairs with 1-entry occupancy (pointer wrap) → data order preserved, `level` never exceeds 1.
- Level 3, `flush` with `w_req`=1 and data 0x77 → `level`=0, `unempty`=0, and 0x77 is not stored.
- Macro defined: write while full → `ovf`=1. `err_clr` together with a read on empty → `udf`=1 and `ovf`=0. `ovf` and `udf` persist across `flush`.
- Empty, simultaneous write 0x99 and read → read refused, `unempty`=1 next cycle with `data_o`=0x99. With `ZEROOUT_WHENEMPTY`=1, `data_o`=0 while empty.
